// File: rtl/hilo_unit_pkg.sv
// rtl/hilo_unit_pkg.sv - shared constants and state encoding for the HI/LO unit
package hilo_unit_pkg;

    localparam int HILO_DATA_W   = 32;
    localparam int HILO_MAX_WAIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_DISCARD = 2'b10
    } hilo_state_e;

endpackage

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - architectural HI/LO registers with multiply tracking, MT ordering and MF bypass
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W   = HILO_DATA_W,
    parameter int MAX_WAIT = HILO_MAX_WAIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mul_start,
    input  logic                mul_complete,
    input  logic [2*DATA_W-1:0] mul_result,
    input  logic                mthi_en,
    input  logic                mtlo_en,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                mf_req,
    input  logic                mf_sel,
    input  logic                flush,
    output logic [DATA_W-1:0]   rdata,
    output logic                stall,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                pending,
    output logic                err_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    hilo_state_e       state_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              hi_own_q;
    logic              lo_own_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_own_q   <= 1'b0;
            lo_own_q   <= 1'b0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_q    <= ST_PENDING;
                        hi_own_q   <= 1'b1;
                        lo_own_q   <= 1'b1;
                        wait_cnt_q <= '0;
                    end
                end
                ST_PENDING: begin
                    if (mul_start) begin
                        err_q <= 1'b1;
                    end
                    if (wait_cnt_q == WAIT_MAX) begin
                        err_q <= 1'b1;
                    end
                    // A completion coinciding with flush is consumed but never committed.
                    if (mul_complete) begin
                        state_q <= ST_IDLE;
                        if (!flush && hi_own_q) begin
                            hi_q <= mul_result[2*DATA_W-1:DATA_W];
                        end
                        if (!flush && lo_own_q) begin
                            lo_q <= mul_result[DATA_W-1:0];
                        end
                    end else if (flush) begin
                        state_q <= ST_DISCARD;
                    end else if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                    if (mthi_en) begin
                        hi_own_q <= 1'b0;
                    end
                    if (mtlo_en) begin
                        lo_own_q <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (mul_complete) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed last so an MT write overrides a same-cycle product commit.
            if (mthi_en) begin
                hi_q <= wdata;
            end
            if (mtlo_en) begin
                lo_q <= wdata;
            end
        end
    end

    logic              sel_own;
    logic              sel_mt;
    logic [DATA_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_prod;

    always_comb begin
        sel_own  = mf_sel ? hi_own_q : lo_own_q;
        sel_mt   = mf_sel ? mthi_en : mtlo_en;
        sel_reg  = mf_sel ? hi_q : lo_q;
        sel_prod = mf_sel ? mul_result[2*DATA_W-1:DATA_W] : mul_result[DATA_W-1:0];
        rdata    = '0;
        stall    = 1'b0;
        if (!reset) begin
            if (sel_mt) begin
                rdata = wdata;
            end else if (state_q == ST_PENDING && sel_own && mul_complete) begin
                rdata = sel_prod;
            end else begin
                rdata = sel_reg;
            end
            if (mf_req && !flush) begin
                stall = (state_q == ST_DISCARD) ||
                        (state_q == ST_PENDING && sel_own && !mul_complete);
            end
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign pending     = (state_q != ST_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;

    logic        clk;
    logic        reset;
    logic        mul_start;
    logic        mul_complete;
    logic [63:0] mul_result;
    logic        mthi_en;
    logic        mtlo_en;
    logic [31:0] wdata;
    logic        mf_req;
    logic        mf_sel;
    logic        flush;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        pending;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mul_start    (mul_start),
        .mul_complete (mul_complete),
        .mul_result   (mul_result),
        .mthi_en      (mthi_en),
        .mtlo_en      (mtlo_en),
        .wdata        (wdata),
        .mf_req       (mf_req),
        .mf_sel       (mf_sel),
        .flush        (flush),
        .rdata        (rdata),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .pending      (pending),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        mul_start    = 1'b0;
        mul_complete = 1'b0;
        mul_result   = '0;
        mthi_en      = 1'b0;
        mtlo_en      = 1'b0;
        wdata        = '0;
        mf_req       = 1'b1;
        mf_sel       = 1'b1;
        flush        = 1'b0;
        #2;
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mf_req = 1'b0;

        // basic commit, stalled MFHI, then bypass in the complete cycle
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        check_eq("t1_pending", pending, 1);
        mf_req = 1'b1;
        mf_sel = 1'b1;
        @(negedge clk);
        check_eq("t1_stall_wait", stall, 1);
        tick();
        mul_complete = 1'b1;
        mul_result   = 64'h00000001_FFFFFFFE;
        @(negedge clk);
        check_eq("t1_stall_done", stall, 0);
        check_eq("t1_bypass_hi", rdata, 32'h00000001);
        mf_sel = 1'b0;
        #1;
        check_eq("t1_bypass_lo", rdata, 32'hFFFFFFFE);
        check_eq("t1_stall_lo", stall, 0);
        tick();
        mul_complete = 1'b0;
        mf_req       = 1'b0;
        check_eq("t1_hi", hi, 32'h00000001);
        check_eq("t1_lo", lo, 32'hFFFFFFFE);
        check_eq("t1_pending_drop", pending, 0);

        // MTLO during a pending multiply keeps LO
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        mtlo_en   = 1'b1;
        wdata     = 32'd5;
        tick();
        mtlo_en = 1'b0;
        check_eq("t2_lo_mt", lo, 5);
        check_eq("t2_pending", pending, 1);
        mf_req = 1'b1;
        mf_sel = 1'b0;
        @(negedge clk);
        check_eq("t2_mflo_stall", stall, 0);
        check_eq("t2_mflo_rdata", rdata, 5);
        mf_sel = 1'b1;
        #1;
        check_eq("t2_mfhi_stall", stall, 1);
        tick();
        mf_req       = 1'b0;
        mul_complete = 1'b1;
        mul_result   = 64'hAAAABBBB_CCCCDDDD;
        tick();
        mul_complete = 1'b0;
        check_eq("t2_hi", hi, 32'hAAAABBBB);
        check_eq("t2_lo", lo, 32'd5);

        // MTHI forwarded to a same-cycle MFHI in IDLE
        mthi_en = 1'b1;
        wdata   = 32'h00001234;
        mf_req  = 1'b1;
        mf_sel  = 1'b1;
        @(negedge clk);
        check_eq("t3_fwd_rdata", rdata, 32'h00001234);
        check_eq("t3_fwd_stall", stall, 0);
        tick();
        mthi_en = 1'b0;
        mf_req  = 1'b0;
        check_eq("t3_hi", hi, 32'h00001234);

        // flush discards the outstanding product
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t4_pending_discard", pending, 1);
        mf_req = 1'b1;
        mf_sel = 1'b1;
        @(negedge clk);
        check_eq("t4_discard_stall", stall, 1);
        flush = 1'b1;
        #1;
        check_eq("t4_flush_nostall", stall, 0);
        flush  = 1'b0;
        mf_req = 1'b0;
        tick();
        mul_complete = 1'b1;
        mul_result   = 64'hFFFFFFFF_FFFFFFFF;
        @(negedge clk);
        check_eq("t4_pending_at_cmp", pending, 1);
        tick();
        mul_complete = 1'b0;
        check_eq("t4_pending_drop", pending, 0);
        check_eq("t4_hi", hi, 32'h00001234);
        check_eq("t4_lo", lo, 32'd5);

        // asynchronous reset while pending
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        mf_req    = 1'b1;
        mf_sel    = 1'b1;
        @(negedge clk);
        check_eq("t5_stall_pre", stall, 1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t5_hi", hi, 0);
        check_eq("t5_lo", lo, 0);
        check_eq("t5_pending", pending, 0);
        check_eq("t5_stall", stall, 0);
        check_eq("t5_rdata", rdata, 0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        mf_req       = 1'b0;
        mul_complete = 1'b1;
        mul_result   = 64'hDEADBEEF_CAFEF00D;
        tick();
        mul_complete = 1'b0;
        check_eq("t5_stray_hi", hi, 0);
        check_eq("t5_stray_lo", lo, 0);
        check_eq("t5_stray_pending", pending, 0);

        // timeout after MAX_WAIT idle cycles in PENDING, sticky afterwards
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        repeat (7) tick();
        check_eq("t6_err_early", err_timeout, 0);
        tick();
        check_eq("t6_err_set", err_timeout, 1);
        check_eq("t6_pending", pending, 1);
        mul_complete = 1'b1;
        mul_result   = 64'h00000002_00000003;
        tick();
        mul_complete = 1'b0;
        check_eq("t6_err_sticky", err_timeout, 1);
        check_eq("t6_pending_drop", pending, 0);
        check_eq("t6_hi", hi, 32'd2);
        check_eq("t6_lo", lo, 32'd3);
        tick();
        tick();
        check_eq("t6_err_hold", err_timeout, 1);

        // mul_start while pending is a protocol error
        reset = 1'b1;
        #1;
        check_eq("t7_err_clr", err_timeout, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mul_start = 1'b1;
        tick();
        tick();
        mul_start = 1'b0;
        check_eq("t7_err_proto", err_timeout, 1);
        check_eq("t7_pending", pending, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
